// File: rtl/simple_processor_pkg.sv
// Shared widths and the data-memory responder FSM state type.
`timescale 1ns/1ps
package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;
endpackage

// File: rtl/dmem_sram_array.sv
// Single-port DEPTH x DATA_WIDTH storage: synchronous write, combinational read, no reset.
`timescale 1ns/1ps
module dmem_sram_array
  import simple_processor_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];
endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, fixed read latency, held response.
// Optional address range/alignment checking under DMEM_ADDR_CHECK_EN.
`timescale 1ns/1ps
module data_mem_responder
  import simple_processor_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);
  localparam int AW = $clog2(DEPTH);

  dmem_state_t           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  ready_en_q;
  logic                  accept, bad_addr, mem_we;
  logic [AW-1:0]         word_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign word_idx    = req_addr_i[AW+1:2];
  // ready_en_q keeps ready low during reset and for no longer than the first edge after it
  assign req_ready_o = ready_en_q && (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;

`ifdef DMEM_ADDR_CHECK_EN
  assign bad_addr = (req_addr_i[DATA_WIDTH-1:AW+2] != '0) || (req_addr_i[1:0] != 2'b00);
`else
  logic addr_unused;
  assign addr_unused = ^{req_addr_i[DATA_WIDTH-1:AW+2], req_addr_i[1:0]};
  assign bad_addr    = 1'b0;
`endif

  assign mem_we = accept && req_we_i && !bad_addr;

  dmem_sram_array #(.DEPTH(DEPTH)) u_sram (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (word_idx),
    .wdata_i (req_wdata_i),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        // load data is captured at accept; memory cannot change until the response retires
        err_d  = bad_addr;
        data_d = (req_we_i || bad_addr) ? '0 : mem_rdata;
        if (req_we_i || RD_LATENCY == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RESP;
      end
      RESP: if (rsp_ready_i) begin
        state_d = IDLE;
        data_d  = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? data_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;
endmodule
